// File: rtl/dbus_ctrl.sv
// dbus_ctrl: single-outstanding data-bus to synchronous SRAM bridge.
// Accepts one byte/half/word request at a time. Write data and byte enables
// are steered onto the SRAM lanes, and read data is realigned to bit 0 and
// masked to the requested lanes. Misaligned requests complete immediately
// without touching the SRAM.
module dbus_ctrl #(
    parameter int ADDR_W   = 12,
    parameter int WAIT_CYC = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_dbus_req,
    input  logic              i_dbus_we,
    input  logic [3:0]        i_dbus_sel,
    input  logic [31:0]       i_dbus_addr,
    input  logic [31:0]       i_dbus_wdata,
    output logic [31:0]       o_dbus_rdata,
    output logic              o_dbus_rsp,
    output logic              o_misalign,
    output logic              o_stall,
    output logic              o_ram_en,
    output logic [3:0]        o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [31:0]       o_ram_wdata,
    input  logic [31:0]       i_ram_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYC);

    state_t            state_reg;
    state_t            state_next;
    logic              we_reg;
    logic [3:0]        sel_reg;
    logic [ADDR_W-1:0] word_reg;
    logic [1:0]        off_reg;
    logic [31:0]       wdata_reg;
    logic              mis_reg;
    logic [2:0]        cnt_reg;
    logic              cap_reg;    // SRAM output is valid this cycle (cycle after ACCESS)
    logic [31:0]       hold_reg;   // read word kept across WAIT cycles

    logic              req_mis;
    logic [31:0]       raw_data;
    logic [31:0]       shifted_data;
    logic [31:0]       lane_mask;
    logic [31:0]       wdata_shift;
    logic [3:0]        we_shift;
    logic              unused_addr;

    // Address bits above the SRAM window are not decoded here.
    assign unused_addr = ^i_dbus_addr[31:ADDR_W+2];

    // Halves must be 2-byte aligned, words 4-byte aligned; bytes never fault.
    assign req_mis = ((i_dbus_sel == 4'b0011) && i_dbus_addr[0]) ||
                     ((i_dbus_sel == 4'b1111) && (i_dbus_addr[1:0] != 2'b00));

    // Live SRAM data in the capture cycle, otherwise the held copy, so WAIT
    // cycles never see a re-sampled (possibly stale) SRAM output.
    assign raw_data     = cap_reg ? i_ram_rdata : hold_reg;
    assign shifted_data = raw_data >> {off_reg, 3'b000};
    assign wdata_shift  = wdata_reg << {off_reg, 3'b000};
    assign we_shift     = sel_reg << off_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane_mask
            assign lane_mask[8*gi +: 8] = {8{sel_reg[gi]}};
        end
    endgenerate

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: requests are only looked at in IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (i_dbus_req) begin
                    state_next = req_mis ? RESP : ACCESS;
                end
            end
            ACCESS: state_next = (WAIT_CYC > 0) ? WAIT : RESP;
            WAIT: begin
                if (cnt_reg <= 3'd1) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latch, wait counter and read-data capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            we_reg    <= 1'b0;
            sel_reg   <= 4'b0000;
            word_reg  <= '0;
            off_reg   <= 2'b00;
            wdata_reg <= 32'h0;
            mis_reg   <= 1'b0;
            cnt_reg   <= 3'd0;
            cap_reg   <= 1'b0;
            hold_reg  <= 32'h0;
        end else begin
            if ((state_reg == IDLE) && i_dbus_req) begin
                we_reg    <= i_dbus_we;
                sel_reg   <= i_dbus_sel;
                word_reg  <= i_dbus_addr[ADDR_W+1:2];
                off_reg   <= i_dbus_addr[1:0];
                wdata_reg <= i_dbus_wdata;
                mis_reg   <= req_mis;
            end
            if (state_reg == ACCESS) begin
                cnt_reg <= WAIT_LOAD;
            end else if ((state_reg == WAIT) && (cnt_reg != 3'd0)) begin
                cnt_reg <= cnt_reg - 3'd1;
            end
            cap_reg <= (state_reg == ACCESS) && !we_reg;
            if (cap_reg) begin
                hold_reg <= i_ram_rdata;
            end
        end
    end

    // Output decode: SRAM strobes only in ACCESS, bus response only in RESP.
    always_comb begin
        o_ram_en     = 1'b0;
        o_ram_we     = 4'b0000;
        o_ram_wdata  = 32'h0;
        o_ram_addr   = word_reg;
        o_dbus_rsp   = 1'b0;
        o_misalign   = 1'b0;
        o_dbus_rdata = 32'h0;
        case (state_reg)
            ACCESS: begin
                o_ram_en = 1'b1;
                if (we_reg) begin
                    o_ram_we    = we_shift;
                    o_ram_wdata = wdata_shift;
                end
            end
            RESP: begin
                o_dbus_rsp = 1'b1;
                o_misalign = mis_reg;
                if (!we_reg && !mis_reg) begin
                    o_dbus_rdata = shifted_data & lane_mask;
                end
            end
            default: begin
            end
        endcase
    end

    assign o_stall = i_dbus_req & ~o_dbus_rsp;

endmodule

// File: tb/tb_dbus_ctrl.sv
// Bench for dbus_ctrl: two instances (WAIT_CYC=0 and WAIT_CYC=3), each with a
// behavioural SRAM whose byte at address A initially holds value A.
module tb_dbus_ctrl;

    localparam int AW = 6;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        mis;
        logic [3:0]  ram_we;
        logic [31:0] ram_wd;
        logic [31:0] rd;
    } vec_t;

    typedef struct {
        int          d;
        logic [31:0] rd;
        logic        mis;
        int          rsp_cyc;
    } sb_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_mem = 1'b1;
    int            cyc = 0;
    int            n_chk = 0;
    int            n_fail = 0;

    logic          req [2];
    logic          we [2];
    logic [3:0]    sel [2];
    logic [31:0]   addr [2];
    logic [31:0]   wdata [2];
    logic [31:0]   rdata [2];
    logic          rsp [2];
    logic          mis [2];
    logic          stall [2];
    logic          ram_en [2];
    logic [3:0]    ram_we [2];
    logic [AW-1:0] ram_addr [2];
    logic [31:0]   ram_wdata [2];
    logic [31:0]   ram_rdata [2];

    logic [31:0]   mem [2][64];
    logic [31:0]   q [2];
    logic          vld [2];

    vec_t          tbl [17];
    sb_t           sbq [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            dbus_ctrl #(
                .ADDR_W   (AW),
                .WAIT_CYC ((gi == 0) ? 0 : 3)
            ) dut (
                .i_clk        (clk),
                .i_rst_n      (rst_n),
                .i_dbus_req   (req[gi]),
                .i_dbus_we    (we[gi]),
                .i_dbus_sel   (sel[gi]),
                .i_dbus_addr  (addr[gi]),
                .i_dbus_wdata (wdata[gi]),
                .o_dbus_rdata (rdata[gi]),
                .o_dbus_rsp   (rsp[gi]),
                .o_misalign   (mis[gi]),
                .o_stall      (stall[gi]),
                .o_ram_en     (ram_en[gi]),
                .o_ram_we     (ram_we[gi]),
                .o_ram_addr   (ram_addr[gi]),
                .o_ram_wdata  (ram_wdata[gi]),
                .i_ram_rdata  (ram_rdata[gi])
            );
            // Outside the valid cycle the SRAM output is junk, so any late re-sample shows.
            assign ram_rdata[gi] = vld[gi] ? q[gi] : {16'hBAD0, cyc[15:0]};
        end
    endgenerate

    // Synchronous SRAM models with one-cycle registered read.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (load_mem) begin
                for (int w = 0; w < 64; w++) begin
                    mem[d][w] <= {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
                end
                vld[d] <= 1'b0;
            end else if (ram_en[d]) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_we[d][b]) mem[d][ram_addr[d]][8*b +: 8] <= ram_wdata[d][8*b +: 8];
                end
                q[d]   <= mem[d][ram_addr[d]];
                vld[d] <= 1'b1;
            end else begin
                vld[d] <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic chk_zero(input int d, input string tag);
        chk({tag, "_rsp"},       32'(rsp[d]),       32'h0);
        chk({tag, "_misalign"},  32'(mis[d]),       32'h0);
        chk({tag, "_rdata"},     rdata[d],          32'h0);
        chk({tag, "_ram_en"},    32'(ram_en[d]),    32'h0);
        chk({tag, "_ram_we"},    32'(ram_we[d]),    32'h0);
        chk({tag, "_ram_addr"},  32'(ram_addr[d]),  32'h0);
        chk({tag, "_ram_wdata"}, ram_wdata[d],      32'h0);
    endtask

    // Called just after a rising edge with the DUT idle; returns just after
    // the edge that takes the DUT from RESP back to IDLE, with req dropped.
    task automatic run_txn(input int d, input vec_t v);
        int  k;
        int  seen_en;
        bit  done;
        sb_t e;
        k        = cyc;
        we[d]    = v.we;
        sel[d]   = v.sel;
        addr[d]  = v.addr;
        wdata[d] = v.wdata;
        req[d]   = 1'b1;
        e.d       = d;
        e.rd      = v.rd;
        e.mis     = v.mis;
        e.rsp_cyc = k + (v.mis ? 1 : 2 + wait_of(d));
        sbq.push_back(e);
        seen_en = 0;
        done    = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            chk("stall", 32'(stall[d]), 32'(!rsp[d]));
            if (ram_en[d]) begin
                seen_en++;
                chk("ram_en_cycle", cyc, k + 1);
                chk("ram_we", 32'(ram_we[d]), 32'(v.ram_we));
                chk("ram_addr", 32'(ram_addr[d]), 32'(v.addr[7:2]));
                if (v.we) chk("ram_wdata", ram_wdata[d], v.ram_wd);
            end
            if (rsp[d]) begin
                e = sbq.pop_front();
                chk("rdata", rdata[d], e.rd);
                chk("misalign", 32'(mis[d]), 32'(e.mis));
                chk("rsp_cycle", cyc, e.rsp_cyc);
                chk("ram_en_count", seen_en, e.mis ? 0 : 1);
                $display("txn dut%0d we=%0d sel=%b addr=0x%02h wdata=0x%08h -> rdata=0x%08h misalign=%0d latency=%0d",
                         d, v.we, v.sel, v.addr, v.wdata, rdata[d], mis[d], cyc - k);
                done = 1'b1;
            end else if (i >= 1) begin
                // Request is latched; changing the bus now must not matter.
                we[d]    = 1'($urandom);
                sel[d]   = 4'($urandom);
                addr[d]  = $urandom;
                wdata[d] = $urandom;
            end
        end
        chk("rsp_seen", 32'(done), 32'h1);
        if (!done) sbq.delete();
        @(posedge clk);
        #1;
        req[d] = 1'b0;
    endtask

    initial begin
        //            we    sel    addr    wdata          mis   ram_we  ram_wd         rd
        tbl[0]  = '{1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, 4'hF, 32'hDEADBEEF, 32'h0};
        tbl[1]  = '{1'b0, 4'hF, 32'h10, 32'h0,        1'b0, 4'h0, 32'h0,        32'hDEADBEEF};
        tbl[2]  = '{1'b1, 4'hF, 32'h10, 32'hAABBCCDD, 1'b0, 4'hF, 32'hAABBCCDD, 32'h0};
        tbl[3]  = '{1'b0, 4'h1, 32'h13, 32'h0,        1'b0, 4'h0, 32'h0,        32'h000000AA};
        tbl[4]  = '{1'b0, 4'h1, 32'h11, 32'h0,        1'b0, 4'h0, 32'h0,        32'h000000CC};
        tbl[5]  = '{1'b0, 4'h3, 32'h12, 32'h0,        1'b0, 4'h0, 32'h0,        32'h0000AABB};
        tbl[6]  = '{1'b1, 4'h3, 32'h22, 32'h00001234, 1'b0, 4'hC, 32'h12340000, 32'h0};
        tbl[7]  = '{1'b0, 4'hF, 32'h20, 32'h0,        1'b0, 4'h0, 32'h0,        32'h12342120};
        tbl[8]  = '{1'b0, 4'h3, 32'h20, 32'h0,        1'b0, 4'h0, 32'h0,        32'h00002120};
        tbl[9]  = '{1'b1, 4'h1, 32'h31, 32'hFFFFFF5A, 1'b0, 4'h2, 32'hFFFF5A00, 32'h0};
        tbl[10] = '{1'b0, 4'hF, 32'h30, 32'h0,        1'b0, 4'h0, 32'h0,        32'h33325A30};
        tbl[11] = '{1'b0, 4'hF, 32'h05, 32'h0,        1'b1, 4'h0, 32'h0,        32'h0};
        tbl[12] = '{1'b0, 4'h3, 32'h13, 32'h0,        1'b1, 4'h0, 32'h0,        32'h0};
        tbl[13] = '{1'b1, 4'hF, 32'h0A, 32'h11111111, 1'b1, 4'h0, 32'h0,        32'h0};
        tbl[14] = '{1'b0, 4'hF, 32'h08, 32'h0,        1'b0, 4'h0, 32'h0,        32'h0B0A0908};
        tbl[15] = '{1'b0, 4'h3, 32'h3E, 32'h0,        1'b0, 4'h0, 32'h0,        32'h00003F3E};
        tbl[16] = '{1'b0, 4'h1, 32'h3D, 32'h0,        1'b0, 4'h0, 32'h0,        32'h0000003D};

        for (int d = 0; d < 2; d++) begin
            req[d]   = 1'b0;
            we[d]    = 1'b0;
            sel[d]   = 4'h0;
            addr[d]  = 32'h0;
            wdata[d] = 32'h0;
        end

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        load_mem = 1'b0;
        chk_zero(0, "reset0");
        chk_zero(1, "reset1");

        // First request presented with reset release: accepted on the first edge.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) run_txn(0, tbl[i]);

        // WAIT_CYC=3: word read, stall and latency, no second access from held req.
        run_txn(1, '{1'b0, 4'hF, 32'h14, 32'h0, 1'b0, 4'h0, 32'h0, 32'h17161514});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rsp_ram_en", 32'(ram_en[1]), 32'h0);
            chk("post_rsp_rsp", 32'(rsp[1]), 32'h0);
        end
        @(posedge clk);
        #1;
        run_txn(1, '{1'b1, 4'h3, 32'h2E, 32'hCAFEBABE, 1'b0, 4'hC, 32'hBABE0000, 32'h0});
        run_txn(1, '{1'b0, 4'hF, 32'h2C, 32'h0, 1'b0, 4'h0, 32'h0, 32'hBABE2D2C});
        run_txn(1, '{1'b0, 4'h3, 32'h01, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0});

        // Reset in the middle of WAIT aborts the access.
        we[1]   = 1'b0;
        sel[1]  = 4'hF;
        addr[1] = 32'h18;
        req[1]  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_reset_ram_addr", 32'(ram_addr[1]), 32'h6);
        rst_n = 1'b0;
        #1;
        chk_zero(1, "rst_wait");
        req[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("after_abort_rsp", 32'(rsp[1]), 32'h0);
            chk("after_abort_ram_en", 32'(ram_en[1]), 32'h0);
        end
        @(posedge clk);
        #1;
        run_txn(1, '{1'b0, 4'hF, 32'h18, 32'h0, 1'b0, 4'h0, 32'h0, 32'h1B1A1918});

        // Second reset pulse, then a request that must be taken on the first edge.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_txn(0, '{1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 4'h0, 32'h0, 32'hAABBCCDD});

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dbus_ctrl.md
DBUS_CTRL -- requirements
Module: dbus_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, word-address width of the data SRAM (4*2^ADDR_W bytes).
REQ-002 SHALL have parameter WAIT_CYC, default 0, extra SRAM wait cycles, range 0..7.
REQ-003 SHALL have port i_clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port i_dbus_req  in  1  access request, held by requester until rsp.
REQ-006 SHALL have port i_dbus_we  in  1  1 = write, 0 = read.
REQ-007 SHALL have port i_dbus_sel  in  4  low-aligned lane enables: 0001 byte, 0011 half, 1111 word.
REQ-008 SHALL have port i_dbus_addr  in  32  byte address.
REQ-009 SHALL have port i_dbus_wdata  in  32  low-aligned write data.
REQ-010 SHALL have port o_dbus_rdata  out  32  low-aligned read data, valid only with o_dbus_rsp.
REQ-011 SHALL have port o_dbus_rsp  out  1  one-cycle completion pulse.
REQ-012 SHALL have port o_misalign  out  1  one-cycle pulse with o_dbus_rsp when access was misaligned.
REQ-013 SHALL have port o_stall  out  1  pipeline hold = i_dbus_req & ~o_dbus_rsp (combinational).
REQ-014 SHALL have port o_ram_en  out  1  SRAM enable.
REQ-015 SHALL have port o_ram_we  out  4  SRAM per-byte write enables.
REQ-016 SHALL have port o_ram_addr  out  ADDR_W  SRAM word address = addr[ADDR_W+1:2].
REQ-017 SHALL have port o_ram_wdata  out  32  lane-shifted write data.
REQ-018 SHALL have port i_ram_rdata  in  32  SRAM read data, valid the cycle after o_ram_en.

Function
REQ-019 SHALL implement states IDLE, ACCESS, WAIT, RESP.
REQ-020 IDLE: on i_dbus_req=1 SHALL register we, sel, addr, wdata; aligned -> ACCESS, misaligned -> RESP with misalign flag set.
REQ-021 Misaligned: sel=0011 with addr[0]=1, or sel=1111 with addr[1:0]!=0; SHALL never assert o_ram_en.
REQ-022 ACCESS (one cycle): o_ram_en=1, o_ram_addr from latched addr; write: o_ram_we = sel<<addr[1:0], o_ram_wdata = wdata<<(8*addr[1:0]); read: o_ram_we=0000.
REQ-023 ACCESS -> WAIT if WAIT_CYC>0, else -> RESP; WAIT SHALL last exactly WAIT_CYC cycles (3-bit down-counter), then -> RESP.
REQ-024 Read data SHALL be captured from i_ram_rdata on the cycle after ACCESS; it SHALL NOT be re-sampled during WAIT.
REQ-025 Read data SHALL be shifted right by 8*addr[1:0] and masked to sel lanes (unused bytes 0); sign extension is not done here.
REQ-026 RESP (one cycle): o_dbus_rsp=1, o_dbus_rdata valid (0 for writes and misaligned), o_misalign per flag; -> IDLE unconditionally.
REQ-027 i_dbus_req SHALL be sampled only in IDLE; a req still high during RESP SHALL NOT start a second access.
REQ-028 Latency: aligned access accepted in IDLE at cycle T SHALL respond at T+2+WAIT_CYC; misaligned at T+1.
REQ-029 Outside ACCESS: o_ram_en=0, o_ram_we=0000; outside RESP: o_dbus_rsp=0, o_misalign=0, o_dbus_rdata=0.
REQ-030 Inputs changing after acceptance SHALL have no effect until the next IDLE sample.

Reset
REQ-031 On i_rst_n=0, asynchronously: state IDLE, counter 0, all registered outputs 0 (rdata, rsp, misalign, ram_en, ram_we, ram_addr, ram_wdata).
REQ-032 Reset mid-access SHALL abort it: no o_ram_en or o_dbus_rsp after reset release until a new request.
REQ-033 First request SHALL be accepted on the first rising edge with i_rst_n=1.

Verification
REQ-034 Word write addr 0x10, wdata 0xDEADBEEF, sel 1111, WAIT_CYC=0 -> ACCESS at T+1 with ram_addr 4, ram_we 1111, ram_wdata 0xDEADBEEF; rsp at T+2.
REQ-035 Byte read addr 0x13, SRAM word 0xAABBCCDD -> ram_we 0000, o_dbus_rdata 0x000000AA at rsp (T+2).
REQ-036 Half write addr 0x22, wdata 0x00001234, sel 0011 -> ram_we 1100, ram_wdata 0x12340000.
REQ-037 Word read addr 0x05 -> o_misalign=1 and rsp at T+1, rdata 0, o_ram_en never asserted.
REQ-038 WAIT_CYC=3, word read -> rsp at T+5, o_stall high T..T+4, low at T+5; req held through RESP causes no second ram_en.
REQ-039 Assert i_rst_n=0 during WAIT -> all outputs 0 immediately; after release no rsp until new req.
